// File: rtl/seg7_rx.sv
// Receive side of the 7-segment display path: synchronizes the segment bus,
// waits for a stable pattern, decodes it to hex and offers it on valid/ready.
module seg7_rx #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_code,
  output logic       out_dp,
  output logic       out_err,
  output logic       out_ambig,
  output logic       out_overrun
);

  localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  // Returns {ambig, err, code}; 0x7C is the encoder's shared glyph for 6 and B.
  function automatic logic [5:0] decode_glyph(input logic [6:0] pat);
    logic [5:0] res;
    case (pat)
      7'h3F:   res = {1'b0, 1'b0, 4'h0};
      7'h06:   res = {1'b0, 1'b0, 4'h1};
      7'h5B:   res = {1'b0, 1'b0, 4'h2};
      7'h4F:   res = {1'b0, 1'b0, 4'h3};
      7'h66:   res = {1'b0, 1'b0, 4'h4};
      7'h6D:   res = {1'b0, 1'b0, 4'h5};
      7'h7D:   res = {1'b0, 1'b0, 4'h6};
      7'h07:   res = {1'b0, 1'b0, 4'h7};
      7'h7F:   res = {1'b0, 1'b0, 4'h8};
      7'h67:   res = {1'b0, 1'b0, 4'h9};
      7'h77:   res = {1'b0, 1'b0, 4'hA};
      7'h7C:   res = {1'b1, 1'b0, 4'hB};
      7'h39:   res = {1'b0, 1'b0, 4'hC};
      7'h5E:   res = {1'b0, 1'b0, 4'hD};
      7'h79:   res = {1'b0, 1'b0, 4'hE};
      7'h71:   res = {1'b0, 1'b0, 4'hF};
      default: res = {1'b0, 1'b1, 4'h0};
    endcase
    return res;
  endfunction

  logic [7:0]    sync1_q, sync1_d;
  logic [7:0]    sync2_q, sync2_d;
  logic [7:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    last_q, last_d;
  state_e        state_q, state_d;
  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic          dp_q, dp_d;
  logic          err_q, err_d;
  logic          ambig_q, ambig_d;
  logic          ovr_q, ovr_d;
  logic          qualify_s;
  logic [5:0]    dec_s;

  // Synchronizer, stability tracker and one-shot qualify detection.
  always_comb begin
    sync1_d = seg_in;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CW'(1);
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    qualify_s = (cnt_q == CNT_MAX) && (cand_q != last_q);
    dec_s     = decode_glyph(cand_q[6:0]);
    if (qualify_s) begin
      last_d = cand_q;
    end else begin
      last_d = last_q;
    end
  end

  // Output buffer: a ready consumer in FULL may take a record and receive the next in the same edge.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    dp_d    = dp_q;
    err_d   = err_q;
    ambig_d = ambig_q;
    ovr_d   = ovr_q;
    case (state_q)
      EMPTY: begin
        if (qualify_s) begin
          state_d = FULL;
          valid_d = 1'b1;
          code_d  = dec_s[3:0];
          dp_d    = cand_q[7];
          err_d   = dec_s[4];
          ambig_d = dec_s[5];
          ovr_d   = 1'b0;
        end else begin
          valid_d = 1'b0;
        end
      end
      FULL: begin
        if (out_ready && qualify_s) begin
          valid_d = 1'b1;
          code_d  = dec_s[3:0];
          dp_d    = cand_q[7];
          err_d   = dec_s[4];
          ambig_d = dec_s[5];
          ovr_d   = 1'b0;
        end else if (out_ready) begin
          state_d = EMPTY;
          valid_d = 1'b0;
        end else if (qualify_s) begin
          ovr_d = 1'b1;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
        valid_d = 1'b0;
      end
    endcase
  end

  // Input pipeline and tracker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
      cand_q  <= 8'h00;
      cnt_q   <= '0;
      last_q  <= 8'h00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Output state machine with registered record fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      code_q  <= 4'h0;
      dp_q    <= 1'b0;
      err_q   <= 1'b0;
      ambig_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      dp_q    <= dp_d;
      err_q   <= err_d;
      ambig_q <= ambig_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_code    = code_q;
  assign out_dp      = dp_q;
  assign out_err     = err_q;
  assign out_ambig   = ambig_q;
  assign out_overrun = ovr_q;

endmodule

// File: tb/tb_seg7_rx.sv
// Scoreboard bench for seg7_rx: a reference model of the receive rules predicts
// each delivered record; a monitor compares records as they are handed over.
module tb_seg7_rx;

  localparam int S = 4;
  localparam logic [6:0] GLYPH [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_code;
  logic       out_dp, out_err, out_ambig, out_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q [$];

  seg7_rx #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_code(out_code), .out_dp(out_dp),
    .out_err(out_err), .out_ambig(out_ambig), .out_overrun(out_overrun)
  );

  always #5 clk = ~clk;

  // {code, dp, err, ambig} by table lookup over the glyph set
  function automatic logic [6:0] mdec(input logic [7:0] p);
    logic [3:0] c;
    logic       e;
    c = 4'h0;
    e = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (GLYPH[i] == p[6:0]) begin
        c = 4'(i);
        e = 1'b0;
      end
    end
    return {c, p[7], e, (p[6:0] == 7'h7C)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [7:0] h_new, h_old, run_val, last_m;
  int         run_len;
  logic       pend_m, ovr_m, ev;
  logic [6:0] rec_m;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        h_new = 8'h00; h_old = 8'h00; run_val = 8'h00; run_len = 0;
        last_m = 8'h00; pend_m = 1'b0; ovr_m = 1'b0; rec_m = 7'h00;
      end else begin
        ev = (run_len == S) && (run_val != last_m);
        if (pend_m && out_ready) exp_q.push_back({rec_m, ovr_m});
        if (ev) begin
          last_m = run_val;
          if (!pend_m || out_ready) begin
            rec_m = mdec(run_val); ovr_m = 1'b0; pend_m = 1'b1;
          end else begin
            ovr_m = 1'b1;
          end
        end else if (pend_m && out_ready) begin
          pend_m = 1'b0;
        end
        if (h_old != run_val) begin
          run_val = h_old; run_len = 1;
        end else if (run_len < S) begin
          run_len++;
        end
        h_old = h_new;
        h_new = seg_in;
      end
    end
  end

  // Monitor: valid tracking every cycle, record contents at each handover
  initial begin
    logic [7:0] obs;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("valid_track", 32'(out_valid), 32'(pend_m));
        if (out_valid && out_ready) begin
          obs = {out_code, out_dp, out_err, out_ambig, out_overrun};
          @(posedge clk);
          #2;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL record_unexpected: got %0h, expected none", obs);
          end else begin
            want = exp_q.pop_front();
            chk("record", 32'(obs), 32'(want));
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] pats [4];
    logic [6:0] fld  [4];
    logic [7:0] pat;
    int         hold;
    pats = '{8'hFF, 8'h7C, 8'h80, 8'h7D};
    fld  = '{{4'h8, 1'b1, 1'b0, 1'b0}, {4'hB, 1'b0, 1'b0, 1'b1},
             {4'h0, 1'b1, 1'b1, 1'b0}, {4'h6, 1'b0, 1'b0, 1'b0}};
    rst_n = 1'b0; seg_in = 8'h00; out_ready = 1'b1;
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_fields", 32'({out_code, out_dp, out_err, out_ambig, out_overrun}), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("blank_no_record", 32'(out_valid), 32'd0);

    // Latency: valid appears exactly after the seventh edge
    seg_in = 8'h4F;
    for (int e = 0; e <= 6; e++) begin
      step(1);
      if (e < 6) chk("lat_wait", 32'(out_valid), 32'd0);
    end
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_fields", 32'({out_code, out_dp, out_err, out_ambig}), 32'({4'h3, 3'b000}));
    step(10);
    chk("held_once", 32'(out_valid), 32'd0);

    // Glitch shorter than the filter, then return to the emitted pattern
    seg_in = 8'h06; step(3);
    seg_in = 8'h4F; step(10);
    chk("glitch_ignored", 32'(out_valid), 32'd0);

    for (int k = 0; k < 4; k++) begin
      seg_in = pats[k];
      step(7);
      chk("decode_valid", 32'(out_valid), 32'd1);
      chk("decode_fields", 32'({out_code, out_dp, out_err, out_ambig}), 32'(fld[k]));
      step(3);
    end

    // Overrun while the consumer stalls
    out_ready = 1'b0;
    seg_in = 8'h06; step(8);
    seg_in = 8'h5B; step(8);
    chk("ovr_valid", 32'(out_valid), 32'd1);
    chk("ovr_code", 32'(out_code), 32'h1);
    chk("ovr_flag", 32'(out_overrun), 32'd1);
    out_ready = 1'b1; step(1);
    chk("ovr_accept", 32'(out_valid), 32'd0);
    step(10);
    chk("ovr_lost", 32'(out_valid), 32'd0);

    // Transfer and reload on the same edge
    out_ready = 1'b0;
    seg_in = 8'h06; step(8);
    seg_in = 8'h66; step(6);
    chk("b2b_before", 32'({out_valid, out_code}), 32'({1'b1, 4'h1}));
    out_ready = 1'b1; step(1);
    chk("b2b_after", 32'({out_valid, out_code, out_overrun}), 32'({1'b1, 4'h4, 1'b0}));
    step(2);

    // Reset while a record is pending
    out_ready = 1'b0;
    seg_in = 8'h6D; step(8);
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({out_valid, out_code, out_dp, out_err, out_ambig, out_overrun}), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("rst_requal_wait", 32'(out_valid), 32'd0);
    step(1);
    chk("rst_requal", 32'({out_valid, out_code}), 32'({1'b1, 4'h5}));
    out_ready = 1'b1; step(2);

    // Randomized patterns, hold times and consumer back-pressure
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) pat = 8'($urandom);
      else pat = {1'($urandom), GLYPH[$urandom_range(0, 15)]};
      seg_in = pat;
      hold = $urandom_range(1, 9);
      for (int j = 0; j < hold; j++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        step(1);
      end
    end
    out_ready = 1'b1;
    step(20);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_rx.md
Name: seg7_rx

Overview:
- Receive-side counterpart of the team's hex-to-7-segment encoder.
- Samples an external 8-bit segment bus (pgfedcba), waits until the pattern has been stable for a programmable number of cycles, then decodes it back to a 4-bit hex code.
- Delivers each new code through a valid/ready handshake, with error, ambiguity and overrun flags.
- Used for loopback self-test of the display path and for reading a neighbouring design's display pins.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronized cycles a pattern must hold before it qualifies; legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- seg_in  input  8  asynchronous segment bus, bit7=p, bit6=g … bit0=a
- out_ready  input  1  consumer accepts the pending record this cycle
- out_valid  output  1  a decoded record is pending
- out_code  output  4  decoded hex value
- out_dp  output  1  decimal point (seg bit7) of the pattern
- out_err  output  1  pattern (bits 6:0) matches no hex glyph
- out_ambig  output  1  pattern 0x7C, which the team's encoder drives for both 6 and B
- out_overrun  output  1  at least one qualified record was dropped while this one was pending

Behaviour:
- Reset (async assert, sync release): all outputs 0; synchronizer flops 0x00; candidate 0x00; counter 0; last_emitted 0x00.
- Input sync: seg_in passes through a 2-flop synchronizer to give seg_s. No logic uses seg_in directly.
- Stability tracker, each edge:
  - If seg_s != candidate: candidate <= seg_s, cnt <= 1.
  - Else if cnt < STABLE_CYCLES: cnt <= cnt+1.
  - cnt saturates at STABLE_CYCLES.
- Qualify event: occurs in a cycle where cnt == STABLE_CYCLES and candidate != last_emitted (all 8 bits compared).
  - On the event, last_emitted <= candidate. Each stable pattern therefore produces exactly one event.
  - Patterns held for fewer than STABLE_CYCLES synchronized cycles are ignored (glitch filter).
  - A blank bus (0x00) at reset produces nothing.
- Latency: seg_in stable from before edge k gives out_valid high after edge k+STABLE_CYCLES+2.
- Decode, combinational on candidate[6:0]:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 67→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - 0x7C decodes to B with ambig=1.
  - Any other value gives code=0, err=1.
  - dp = candidate[7], independent of err.
- Output state machine, two states:
  - EMPTY: out_valid=0. On a qualify event, load out_code/out_dp/out_err/out_ambig, clear out_overrun, go to FULL.
  - FULL: out_valid=1 and the record is held stable.
    - out_ready=1 with no event: go to EMPTY.
    - out_ready=1 with a simultaneous event: load the new record, stay FULL, out_overrun=0 (transfer and reload in the same cycle, no bubble).
    - out_ready=0 with an event: keep the old record, set out_overrun=1 (sticky until this record is accepted). The new pattern still updates last_emitted and is lost.
- out_ready is ignored in EMPTY.
- Output flags (out_err, out_ambig, out_dp, out_overrun) are meaningful only while out_valid=1. They hold their last values otherwise.
- Reset asserted mid-operation: the pending record is discarded immediately and all state returns to reset values. After release, a still-present pattern requalifies and is emitted.
- Counter width is $clog2(STABLE_CYCLES+1), minimum 1 bit.

Test Plan:
- STABLE_CYCLES=4, out_ready=1, seg_in 0x00→0x4F held before edge 0 → out_valid=1 after edge 6, out_code=3, err=0, ambig=0, dp=0; exactly one record, none while held.
- seg_in 0x4F, then a 3-cycle glitch to 0x06, then back to 0x4F, STABLE_CYCLES=4 → no record emitted for the glitch or the return.
- seg_in 0xFF → code=8, dp=1. seg_in 0x7C → code=B, ambig=1. seg_in 0x80 → err=1, code=0, dp=1. seg_in 0x7D → code=6, ambig=0.
- out_ready=0, apply 0x06 then 0x5B (each stable ≥6 cycles) → record stays code=1, overrun=1. Raise out_ready → accepted, out_valid drops, and no 0x5B record follows.
- FULL with code=1, out_ready=1 in the same cycle 0x66 qualifies → next cycle out_valid=1, code=4, overrun=0, no idle cycle.
- Assert rst_n=0 while out_valid=1 (seg_in=0x6D) → all outputs 0 asynchronously. Release → code=5 re-emitted STABLE_CYCLES+2 edges later.
